// File: rtl/bus_receiver.sv
// Byte-serial request bus receiver: assembles NBEATS-beat frames into {cmd, addr} words,
// buffers them in a small FIFO and issues bus_ready credit. Optional BUS_RX_ERRCNT_EN adds an error counter.
module bus_receiver #(
  parameter int ADDRW = 24,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic             bus_ready,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [ADDRW-1:0] addr_out,
  output logic [7:0]       cmd_out,
  output logic             frame_err
`ifdef BUS_RX_ERRCNT_EN
  ,
  input  logic             err_clr,
  output logic [7:0]       err_cnt
`endif
);

  localparam int NBEATS = ADDRW / 8 + 1;
  localparam int WW     = ADDRW + 8;
  localparam int BW     = $clog2(NBEATS);
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);

  logic [BW-1:0] beat_cnt;
  logic [WW-1:0] asm_q;
  logic [WW-1:0] word_in;
  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          frame_err_q;
  logic          last_beat;
  logic          short_frame;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          overflow;
  logic          pending;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The word pushed on the last beat must include the byte arriving that cycle.
  always_comb begin
    word_in = asm_q;
    word_in[{beat_cnt, 3'b000} +: 8] = data_in;
  end

  assign last_beat   = valid_in && (beat_cnt == BW'(NBEATS - 1));
  assign short_frame = !valid_in && (beat_cnt != '0);
  assign push        = last_beat;
  assign pop         = word_valid && word_ready;
  assign full        = (count == CW'(DEPTH));
  assign push_ok     = push && (!full || pop);
  assign overflow    = push && full && !pop;

  // Credit reserves a slot for the frame in flight, so only valid_in (never data_in) feeds it.
  assign pending   = (beat_cnt != '0) || valid_in;
  assign occ       = {1'b0, count} + (CW + 1)'(pending);
  assign bus_ready = (occ < (CW + 1)'(DEPTH));

  assign head       = mem[rd_ptr];
  assign word_valid = (count != '0);
  assign addr_out   = head[ADDRW-1:0];
  assign cmd_out    = head[WW-1:ADDRW];
  assign frame_err  = frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      asm_q       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (valid_in) begin
        asm_q    <= word_in;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end else if (short_frame) begin
        asm_q    <= '0;
        beat_cnt <= '0;
      end

      frame_err_q <= short_frame || overflow;

      if (push_ok) begin
        mem[wr_ptr] <= word_in;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef BUS_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (frame_err_q && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule
